// File: rtl/fp_cvt_pkg.sv
// Shared constants and flag type for the FP4 (E2M1) / E8M0 -> FP9 (E5M3) conversion path.
package fp_cvt_pkg;

  localparam int FP4_W       = 4;
  localparam int FP9_W       = 9;
  localparam int FP9_BIAS    = 15;
  localparam int E8M0_BIAS   = 127;
  localparam int FP9_EXP_MAX = 30;

  localparam logic [7:0] E8M0_NAN     = 8'hFF;
  localparam logic [4:0] FP9_EXP_ALL1 = 5'h1F;
  localparam logic [2:0] FP9_QNAN_MAN = 3'b001;

  typedef struct packed {
    logic invalid;
    logic underflow;
    logic overflow;
  } fp9_flags_t;

endpackage

// File: rtl/fp4_lane_cvt.sv
// Combinational conversion of one E2M1 code plus E8M0 shared scale into FP9 and flags.
// Optional macro FP4_NAN_CODE_EN: codes 4'h7/4'hF are treated as NaN instead of +/-6.0.
module fp4_lane_cvt
  import fp_cvt_pkg::*;
(
  input  logic [FP4_W-1:0] code,
  input  logic [7:0]       scale,
  output logic [FP9_W-1:0] fp9,
  output fp9_flags_t       flags
);

  localparam logic signed [9:0] SCALE_OFS = 10'(E8M0_BIAS - FP9_BIAS);
  localparam logic signed [9:0] EXP_MAX   = 10'(FP9_EXP_MAX);

  logic              sign;
  logic [1:0]        exp_code;
  logic              man_code;
  logic              is_zero;
  logic              nan_code;
  logic signed [9:0] unb_exp;
  logic signed [9:0] r_exp;
  logic [2:0]        man;

  assign sign     = code[3];
  assign exp_code = code[2:1];
  assign man_code = code[0];
  assign is_zero  = (code[2:0] == 3'b000);

`ifdef FP4_NAN_CODE_EN
  assign nan_code = (code[2:0] == 3'b111);
`else
  assign nan_code = 1'b0;
`endif

  always_comb begin
    unb_exp = -10'sd1;
    man     = 3'b000;
    if (exp_code != 2'b00) begin
      unb_exp = $signed({8'd0, exp_code}) - 10'sd1;
      man     = {man_code, 2'b00};
    end
    r_exp = unb_exp + $signed({2'b00, scale}) - SCALE_OFS;
  end

  // NaN scale dominates every lane, including zero codes.
  always_comb begin
    fp9   = '0;
    flags = '0;
    if (scale == E8M0_NAN || nan_code) begin
      fp9           = {sign, FP9_EXP_ALL1, FP9_QNAN_MAN};
      flags.invalid = 1'b1;
    end else if (is_zero) begin
      fp9 = {sign, 8'h00};
    end else if (r_exp > EXP_MAX) begin
      fp9            = {sign, FP9_EXP_ALL1, 3'b000};
      flags.overflow = 1'b1;
    end else if (r_exp < 10'sd1) begin
      fp9             = {sign, 8'h00};
      flags.underflow = 1'b1;
    end else begin
      fp9 = {sign, r_exp[4:0], man};
    end
  end

endmodule

// File: rtl/mxfp4_unpack_fp9.sv
// Streaming MXFP4 -> FP9 unpacker: buffers one packed word (stage A) and emits OUT_LANES lanes per beat (stage B).
// Optional macro FP4_NAN_CODE_EN (handled in fp4_lane_cvt) makes codes 4'h7/4'hF convert to NaN.
module mxfp4_unpack_fp9
  import fp_cvt_pkg::*;
#(
  parameter int IN_LANES  = 8,
  parameter int OUT_LANES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FP4_W*IN_LANES-1:0]  in_data,
  input  logic [7:0]                 in_scale,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FP9_W*OUT_LANES-1:0] out_data,
  output logic                       out_last,
  output logic [OUT_LANES-1:0]       out_invalid,
  output logic [OUT_LANES-1:0]       out_underflow,
  output logic [OUT_LANES-1:0]       out_overflow
);

  localparam int BEATS = IN_LANES / OUT_LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic                      live_q, live_d;
  logic                      buf_valid_q, buf_valid_d;
  logic [FP4_W*IN_LANES-1:0] buf_q, buf_d;
  logic [7:0]                scale_q, scale_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;

  logic                       out_valid_q, out_valid_d;
  logic [FP9_W*OUT_LANES-1:0] out_data_q, out_data_d;
  logic                       out_last_q, out_last_d;
  logic [OUT_LANES-1:0]       out_inv_q, out_inv_d;
  logic [OUT_LANES-1:0]       out_unf_q, out_unf_d;
  logic [OUT_LANES-1:0]       out_ovf_q, out_ovf_d;

  logic b_adv;
  logic b_load;
  logic last_beat;
  logic a_accept;

  logic [FP4_W-1:0] lane_code [OUT_LANES];
  logic [FP9_W-1:0] cvt_fp9   [OUT_LANES];
  fp9_flags_t       cvt_flags [OUT_LANES];

  assign b_adv     = !out_valid_q || out_ready;
  assign b_load    = buf_valid_q && b_adv;
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  // live_q keeps in_ready low while reset is asserted and for nothing longer than one edge after release.
  assign in_ready  = live_q && (!buf_valid_q || (last_beat && b_load));
  assign a_accept  = in_valid && in_ready;
  assign live_d    = 1'b1;

  always_comb begin
    for (int j = 0; j < OUT_LANES; j++) begin
      lane_code[j] = buf_q[(int'(beat_cnt_q) * OUT_LANES + j) * FP4_W +: FP4_W];
    end
  end

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
    fp4_lane_cvt u_cvt (
      .code  (lane_code[j]),
      .scale (scale_q),
      .fp9   (cvt_fp9[j]),
      .flags (cvt_flags[j])
    );
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    scale_d     = scale_q;
    beat_cnt_d  = beat_cnt_q;
    if (b_load) begin
      if (last_beat) begin
        buf_valid_d = 1'b0;
        beat_cnt_d  = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
    if (a_accept) begin
      buf_valid_d = 1'b1;
      buf_d       = in_data;
      scale_d     = in_scale;
      beat_cnt_d  = '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_inv_d   = out_inv_q;
    out_unf_d   = out_unf_q;
    out_ovf_d   = out_ovf_q;
    if (b_adv) begin
      out_valid_d = buf_valid_q;
      out_data_d  = '0;
      out_last_d  = 1'b0;
      out_inv_d   = '0;
      out_unf_d   = '0;
      out_ovf_d   = '0;
      if (buf_valid_q) begin
        out_last_d = last_beat;
        for (int j = 0; j < OUT_LANES; j++) begin
          out_data_d[j*FP9_W +: FP9_W] = cvt_fp9[j];
          out_inv_d[j]                 = cvt_flags[j].invalid;
          out_unf_d[j]                 = cvt_flags[j].underflow;
          out_ovf_d[j]                 = cvt_flags[j].overflow;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      scale_q     <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_inv_q   <= '0;
      out_unf_q   <= '0;
      out_ovf_q   <= '0;
    end else begin
      live_q      <= live_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      scale_q     <= scale_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_inv_q   <= out_inv_d;
      out_unf_q   <= out_unf_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign out_invalid   = out_inv_q;
  assign out_underflow = out_unf_q;
  assign out_overflow  = out_ovf_q;

endmodule
